// File: rtl/cmos_burst_sched.sv
// cmos_burst_sched: round-robin burst scheduler draining two line FIFOs into one
// downstream write FIFO, with stall handling and a fixed post-burst idle gap.
module cmos_burst_sched #(
  parameter int BURST_LEN  = 256,
  parameter int GAP_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic ch1_rdy,
  input  logic ch2_rdy,
  input  logic dst_full,
  output logic ch1_rd_en,
  output logic ch2_rd_en,
  output logic sel,
  output logic dst_wr_en,
  output logic burst_done,
  output logic burst_ch
);
  localparam int CW = $clog2(BURST_LEN);
  localparam int GW = $clog2(GAP_CYCLES);
  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic ch_q, ch_d, last_q, last_d;
  logic arm_q, rd1_q, rd2_q, done1_q, done2_q;
  logic rd, last_word, grant, grant_ch1, gap_end;
  assign rd        = (state_q == BURST) && !dst_full;
  assign last_word = rd && (cnt_q == CW'(BURST_LEN - 1));
  // arm_q holds off the first grant until the second edge after reset release
  assign grant     = (state_q == IDLE) && arm_q && enable && (ch1_rdy || ch2_rdy);
  assign grant_ch1 = ch1_rdy && (!ch2_rdy || !last_q);
  assign gap_end   = (gap_q == GW'(GAP_CYCLES - 1));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    ch_d    = ch_q;
    last_d  = last_q;
    if (state_q == IDLE) begin
      if (grant) begin
        state_d = BURST;
        ch_d    = grant_ch1;
        last_d  = grant_ch1;
      end
    end else if (state_q == BURST) begin
      cnt_d   = rd ? (last_word ? '0 : cnt_q + CW'(1)) : cnt_q;
      state_d = last_word ? GAP : BURST;
    end else if (state_q == GAP) begin
      gap_d   = gap_end ? '0 : gap_q + GW'(1);
      state_d = gap_end ? IDLE : GAP;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      ch_q    <= 1'b1;
      last_q  <= 1'b0;
      arm_q   <= 1'b0;
      rd1_q   <= 1'b0;
      rd2_q   <= 1'b0;
      done1_q <= 1'b0;
      done2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      arm_q   <= 1'b1;
      rd1_q   <= rd;
      rd2_q   <= rd1_q;
      done1_q <= last_word;
      done2_q <= done1_q;
    end
  end
  // two-stage delay matches FIFO read latency plus the registered mux
  assign ch1_rd_en  = rd && ch_q;
  assign ch2_rd_en  = rd && !ch_q;
  assign sel        = ch_q;
  assign burst_ch   = ch_q;
  assign dst_wr_en  = rd2_q;
  assign burst_done = done2_q;
endmodule
